alu_result_stage: RTL
=====================

# alu_result_stage

Pipeline stage directly downstream of the 32-bit ALU: captures the ALU result and zero/negative flags with their memory/write-back control, resolves the branch condition from the flags, and hands a registered EX/MEM payload to the memory stage. A two-entry skid buffer decouples ALU issue from memory-stage backpressure. It supports full throughput and a synchronous flush for pipeline redirects.

## Interface
Parameters:
- DW, 32, datapath width (result, store data, branch target)
- RW, 5, register-index width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  ALU output valid this cycle
- in_ready  out  1  stage can accept; equals NOT skid_valid (registered)
- sum  in  DW  ALU result
- zout  in  1  ALU zero flag
- nout  in  1  ALU negative flag (sum[DW-1])
- br_cond  in  3  branch condition code (see Operation)
- br_target  in  DW  precomputed branch target
- store_data  in  DW  rt value for stores
- wb_reg  in  RW  destination register
- reg_write, mem_read, mem_write  in  1 each  control bits
- flush  in  1  discard all held and incoming entries
- out_valid  out  1  payload valid to memory stage
- out_ready  in  1  memory stage accepts
- out_result, out_store_data  out  DW  registered payload
- out_wb_reg  out  RW
- out_reg_write, out_mem_read, out_mem_write  out  1 each
- out_z, out_n  out  1 each  latched flags of the current payload
- branch_taken  out  1  one-cycle pulse
- branch_pc  out  DW  target, valid while branch_taken=1

## Operation
- Condition codes: 000 NONE (never), 001 BEQ (z), 010 BNE (!z), 011 BLTZ (n), 100 BGEZ (!n), 101 BLEZ (z|n), 110 BGTZ (!z & !n), 111 JUMP (always).
- Accept = in_valid & in_ready & !flush.
- On accept: if main empty, or main draining (out_ready=1) with skid empty -> load main; otherwise -> load skid.
- When main drains and skid_valid=1: skid moves to main, skid_valid clears the same edge.
- Accept and skid-to-main in one edge: skid moves to main, new entry goes to skid.
- Branch evaluated at accept; branch_taken=1 and branch_pc=br_target the following cycle, exactly once per entry, independent of out_ready.
- Taken branches still travel as payload (reg_write normally 0).
- flush=1: main_valid, skid_valid, branch_taken cleared next edge; incoming entry dropped; payload data bits need not clear.
- Flags are not recomputed; out_z/out_n are the captured zout/nout.

## Timing
- Latency: accept at edge N -> out_valid=1 with payload after edge N.
- Throughput: one entry/cycle while out_ready=1.
- Handshake: transfer when out_valid & out_ready. out_valid and payload are held stable while out_ready=0. in_ready drops the cycle after skid fills and rises the cycle after skid empties.
- Reset (rst_n=0, asynchronous): out_valid=0, all payload outputs 0, out_z=out_n=0, branch_taken=0, branch_pc=0, skid empty, so in_ready=1 after reset.
- Reset mid-operation discards both entries; no pulse is issued.
- Flush outranks accept and drain in the same cycle.
- Capacity 2: a third in_valid while both are full is not accepted.

## Structure
- Shared package: DW/RW constants; the br_cond encoding as named localparams; an EX/MEM payload struct (result, store_data, wb_reg, reg_write, mem_read, mem_write, z, n).
- One combinational sub-module, alu_branch_eval (br_cond, z, n -> taken), reused by any later early-branch logic.
- Top level contains the skid buffer, the control FSM (EMPTY, ONE, FULL, encoded as main_valid/skid_valid) and the branch pulse register.

## Test plan
- Reset, then sum=0x0000_0005, zout=0, nout=0, br_cond=NONE, reg_write=1, wb_reg=8, out_ready=1 -> next cycle out_valid=1, out_result=5, out_wb_reg=8, branch_taken=0.
- BEQ with zout=1, br_target=0x0040_0020 -> branch_taken pulses one cycle with branch_pc=0x0040_0020. BNE with zout=1 -> no pulse.
- All 8 codes x {z,n} in {00,10,01} -> taken matches the table. BLEZ taken for z=1 or n=1; BGTZ only for 00.
- out_ready=0 for 3 cycles while 3 entries are offered -> 2 accepted, in_ready=0 after the second. Release -> outputs arrive in order A,B, with no loss or duplication.
- Stage FULL, flush=1 together with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the incoming entry never appears.
- rst_n dropped asynchronously mid-cycle while FULL -> outputs are zero immediately, with no branch_taken after release.

Source files
------------

// File: rtl/alu_result_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_stage_pkg
// Description : Shared constants, branch condition codes, EX/MEM payload
//               struct and stage state encoding for the ALU result stage.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_result_stage_pkg;

  // Datapath and register-index widths
  localparam int unsigned c_dw = 32;
  localparam int unsigned c_rw = 5;

  // Branch condition codes presented alongside the ALU result
  localparam logic [2:0] c_br_none = 3'b000;  // never taken
  localparam logic [2:0] c_br_beq  = 3'b001;  // z
  localparam logic [2:0] c_br_bne  = 3'b010;  // !z
  localparam logic [2:0] c_br_bltz = 3'b011;  // n
  localparam logic [2:0] c_br_bgez = 3'b100;  // !n
  localparam logic [2:0] c_br_blez = 3'b101;  // z | n
  localparam logic [2:0] c_br_bgtz = 3'b110;  // !z & !n
  localparam logic [2:0] c_br_jump = 3'b111;  // always taken

  // Payload handed from EX to MEM
  typedef struct packed {
    logic [c_dw-1:0] result;
    logic [c_dw-1:0] store_data;
    logic [c_rw-1:0] wb_reg;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            z;
    logic            n;
  } ex_mem_t;

  // Occupancy state: bit 1 = main entry valid, bit 0 = skid entry valid
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } stage_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_result_stage_branch_eval.sv
`default_nettype none
// ============================================================================
// Module      : alu_branch_eval
// Description : Purely combinational branch resolution from the ALU zero and
//               negative flags. Kept separate so early-branch logic can reuse
//               the same decode.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_branch_eval
  import alu_result_stage_pkg::*;
(
  input  logic [2:0] br_cond,
  input  logic       z,
  input  logic       n,
  output logic       taken
);

  // Decode the condition code against the flags
  always_comb begin
    taken = 1'b0;
    case (br_cond)
      c_br_none: taken = 1'b0;
      c_br_beq:  taken = z;
      c_br_bne:  taken = ~z;
      c_br_bltz: taken = n;
      c_br_bgez: taken = ~n;
      c_br_blez: taken = z | n;
      c_br_bgtz: taken = ~z & ~n;
      c_br_jump: taken = 1'b1;
      default:   taken = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_stage
// Description : EX/MEM pipeline register behind the ALU. Captures result,
//               flags and memory/write-back control into a two-entry skid
//               buffer, resolves the branch at accept time and issues a
//               one-cycle taken pulse. Supports synchronous flush.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_stage
  import alu_result_stage_pkg::*;
#(
  parameter int DW = c_dw,
  parameter int RW = c_rw
) (
  input  logic          clk,
  input  logic          rst_n,
  // ALU side
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] sum,
  input  logic          zout,
  input  logic          nout,
  input  logic [2:0]    br_cond,
  input  logic [DW-1:0] br_target,
  input  logic [DW-1:0] store_data,
  input  logic [RW-1:0] wb_reg,
  input  logic          reg_write,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic          flush,
  // Memory-stage side
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_result,
  output logic [DW-1:0] out_store_data,
  output logic [RW-1:0] out_wb_reg,
  output logic          out_reg_write,
  output logic          out_mem_read,
  output logic          out_mem_write,
  output logic          out_z,
  output logic          out_n,
  // Branch redirect
  output logic          branch_taken,
  output logic [DW-1:0] branch_pc
);

  stage_state_t  state_q, state_d;
  ex_mem_t       main_q, main_d;
  ex_mem_t       skid_q, skid_d;
  ex_mem_t       in_entry;
  logic          branch_taken_q, branch_taken_d;
  logic [DW-1:0] branch_pc_q, branch_pc_d;

  logic          main_valid;
  logic          skid_valid;
  logic          accept;
  logic          drain;
  logic          br_hit;

  assign main_valid = (state_q != ST_EMPTY);
  assign skid_valid = (state_q == ST_FULL);

  // in_ready comes straight from the state register, so it is glitch-free
  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready & ~flush;
  assign drain    = main_valid & out_ready;

  alu_branch_eval u_branch_eval (
    .br_cond (br_cond),
    .z       (zout),
    .n       (nout),
    .taken   (br_hit)
  );

  // Bundle the incoming ALU outputs into one payload word
  always_comb begin
    in_entry            = '0;
    in_entry.result     = sum;
    in_entry.store_data = store_data;
    in_entry.wb_reg     = wb_reg;
    in_entry.reg_write  = reg_write;
    in_entry.mem_read   = mem_read;
    in_entry.mem_write  = mem_write;
    in_entry.z          = zout;
    in_entry.n          = nout;
  end

  // Occupancy FSM and skid-buffer data steering; flush outranks everything
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Data bits are left as they are; only the valid state is discarded
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_d  = in_entry;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (drain) begin
            if (accept) begin
              main_d = in_entry;
            end else begin
              state_d = ST_EMPTY;
            end
          end else if (accept) begin
            skid_d  = in_entry;
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (drain) begin
            main_d = skid_q;
            if (accept) begin
              // Skid refills in the same edge it hands over to main
              skid_d  = in_entry;
              state_d = ST_FULL;
            end else begin
              state_d = ST_ONE;
            end
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // Branch pulse: one cycle after a taken entry is accepted, never on flush
  always_comb begin
    branch_taken_d = accept & br_hit;
    branch_pc_d    = branch_pc_q;
    if (accept & br_hit) begin
      branch_pc_d = br_target;
    end
  end

  // State, payload and branch registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_EMPTY;
      main_q         <= '0;
      skid_q         <= '0;
      branch_taken_q <= 1'b0;
      branch_pc_q    <= '0;
    end else begin
      state_q        <= state_d;
      main_q         <= main_d;
      skid_q         <= skid_d;
      branch_taken_q <= branch_taken_d;
      branch_pc_q    <= branch_pc_d;
    end
  end

  assign out_valid      = main_valid;
  assign out_result     = main_q.result;
  assign out_store_data = main_q.store_data;
  assign out_wb_reg     = main_q.wb_reg;
  assign out_reg_write  = main_q.reg_write;
  assign out_mem_read   = main_q.mem_read;
  assign out_mem_write  = main_q.mem_write;
  assign out_z          = main_q.z;
  assign out_n          = main_q.n;
  assign branch_taken   = branch_taken_q;
  assign branch_pc      = branch_pc_q;

endmodule
`default_nettype wire
